wave_meter: RTL and testbench
=============================

WAVE_METER -- requirements
Module: wave_meter

Interface
REQ-001 Parameter TICK_DIV, default 10, clk cycles per measurement unit (100 ns at 100 MHz); legal range 2..255.
REQ-002 Parameter CNT_W, default 8, width of each measured unit count; legal range 4..16.
REQ-003 clk  input  1  system clock, rising-edge active, 100 MHz nominal.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  measurement enable, synchronous to clk.
REQ-006 wave_in  input  1  square wave under measurement; asynchronous to clk; typically driven by the upstream square-wave generator.
REQ-007 high_units  output  CNT_W  last measured high-phase length in units.
REQ-008 low_units  output  CNT_W  last measured low-phase length in units.
REQ-009 valid  output  1  one-cycle pulse; high_units, low_units and ovf updated this cycle.
REQ-010 ovf  output  1  last measurement had at least one saturated phase.
REQ-011 locked  output  1  high while the FSM is in HIGH or LOW.

Function
REQ-012 wave_in shall pass through a 2-flop synchronizer; all logic shall use only the synchronized level (ws).
REQ-013 An edge shall be detected when ws differs from its previous-cycle value; L = clk cycles between consecutive detected edges.
REQ-014 Phase length in units shall be floor(L / TICK_DIV), saturating at 2^CNT_W-1; the phase counter shall hold (not wrap) once saturated.
REQ-015 Counting shall use a prescaler 0..TICK_DIV-1 plus a unit counter, both restarted on every detected edge; no divider.
REQ-016 FSM states: ACQ, HIGH, LOW; reset state ACQ.
REQ-017 ACQ: falling edges ignored; rising edge -> HIGH, counters cleared (partial first phase discarded).
REQ-018 HIGH: falling edge -> LOW, high count captured internally, counters cleared.
REQ-019 LOW: rising edge -> HIGH; same cycle high_units, low_units and ovf registered, valid pulsed for exactly one cycle, counters cleared.
REQ-020 ovf shall be 1 in a result iff either phase of that measurement saturated.
REQ-021 valid shall rise exactly 3 clk cycles after the first clk edge at which wave_in is sampled high (2 synchronizer + 1 output register).
REQ-022 en=0: FSM forced to ACQ, counters cleared, valid=0, high_units/low_units/ovf hold last values.
REQ-023 en deasserted mid-measurement: partial measurement discarded, no valid; on re-enable, acquisition restarts from ACQ.
REQ-024 Constant ws (no edges): FSM stays in its state, counter saturates, no valid until the next completing rising edge.
REQ-025 Every rising edge in LOW yields a result; back-to-back periods shall produce one valid per period with no lost period.

Reset
REQ-026 reset shall asynchronously set: FSM=ACQ, synchronizer and filter flops=0, counters=0, high_units=0, low_units=0, valid=0, ovf=0, locked=0.
REQ-027 Release of reset shall be sampled synchronously; first result only after a full rising-falling-rising sequence.

Configuration
REQ-028 Macro WAVE_METER_GLITCH_FILTER_EN, when defined, shall insert a 3-sample filter after the synchronizer: filtered level changes only when 3 consecutive ws samples agree.
REQ-029 With the macro, ws pulses shorter than 3 cycles shall be ignored and REQ-021 latency becomes 5 cycles; L unchanged for clean input.
REQ-030 Without the macro, the filter shall be absent, ws used directly, latency 3 cycles.

Verification
REQ-031 Defaults, en=1, wave_in 30 clk high / 50 clk low repeated -> after second rising edge valid pulses, high_units=3, low_units=5, ovf=0, one valid per 80 cycles.
REQ-032 High 29 clk / low 31 clk -> high_units=2, low_units=3.
REQ-033 High 20 clk / low 3000 clk -> low_units=255, high_units=2, ovf=1; next clean 30/50 period -> ovf=0.
REQ-034 en dropped for 5 cycles mid-LOW -> no valid for that period, outputs hold; next valid only after ACQ->HIGH->LOW->rising edge.
REQ-035 reset asserted mid-HIGH -> all outputs 0 immediately (asynchronous), locked=0, FSM in ACQ.
REQ-036 With WAVE_METER_GLITCH_FILTER_EN, 2-cycle high glitch inside a 50-clk low phase -> no edge detected, low_units=5; without macro -> measurement split by glitch.

Source files
------------

// File: rtl/wave_meter.sv
// wave_meter: measures high/low phase lengths of an async square wave in TICK_DIV-cycle units.
// Optional 3-sample glitch filter after the synchronizer: define WAVE_METER_GLITCH_FILTER_EN.
module wave_meter #(
  parameter int TICK_DIV = 10,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wave_in,
  output logic [CNT_W-1:0] high_units,
  output logic [CNT_W-1:0] low_units,
  output logic             valid,
  output logic             ovf,
  output logic             locked
);
  typedef enum logic [1:0] {ACQ, HIGH, LOW} state_t;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state, state_n;
  logic s1, ws, lvl, lvl_d, chg, fall_hi, done;
  logic [PW-1:0] pre;
  logic [CNT_W-1:0] cnt, high_cap;
  always_ff @(posedge clk or posedge reset)
    if (reset) {s1, ws} <= '0;
    else {s1, ws} <= {wave_in, s1};
`ifdef WAVE_METER_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic filt;
  assign lvl = (ws == hist[0] && ws == hist[1]) ? ws : filt;
  always_ff @(posedge clk or posedge reset)
    if (reset) {hist, filt} <= '0;
    else {hist, filt} <= {hist[0], ws, lvl};
`else
  assign lvl = ws;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) lvl_d <= 1'b0;
    else lvl_d <= lvl;
  assign chg     = lvl != lvl_d;
  assign done    = en && chg && lvl && state == LOW;
  assign fall_hi = en && chg && !lvl && state == HIGH;
  assign locked  = state != ACQ;
  always_comb begin
    state_n = !en ? ACQ : !chg ? state : lvl ? HIGH : state == HIGH ? LOW : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ACQ;
    else state <= state_n;
  // the edge cycle itself is the first cycle of the new phase, so restart at 1
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pre <= '0;
      cnt <= '0;
    end else if (!en || chg) begin
      pre <= en ? PW'(1) : '0;
      cnt <= '0;
    end else begin
      pre <= pre == PRE_LAST ? '0 : pre + 1'b1;
      if (pre == PRE_LAST && cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      high_cap   <= '0;
      high_units <= '0;
      low_units  <= '0;
      ovf        <= 1'b0;
      valid      <= 1'b0;
    end else begin
      valid <= done;
      if (fall_hi) high_cap <= cnt;
      if (done) begin
        high_units <= high_cap;
        low_units  <= cnt;
        ovf        <= (high_cap == CNT_MAX) || (cnt == CNT_MAX);
      end
    end
endmodule

// File: tb/tb_wave_meter.sv
// tb_wave_meter: phase-level reference model with scoreboard for wave_meter.
module tb_wave_meter;
  localparam int TD = 10;
  localparam int CW = 8;
  localparam int MAXU = 255;
`ifdef WAVE_METER_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0;
  logic reset, en, wave_in;
  logic [CW-1:0] high_units, low_units;
  logic valid, ovf, locked;
  wave_meter #(.TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .wave_in(wave_in),
    .high_units(high_units), .low_units(low_units),
    .valid(valid), .ovf(ovf), .locked(locked)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int h; int l; int o; int due;} res_t;
  res_t q[$];
  int n_chk = 0, n_fail = 0;
  int exp_h = 0, exp_l = 0, exp_o = 0;
  bit armed = 0, have_lo = 0;
  int hi_len = 0, lo_len = 0;

  function automatic int units(int n);
    return (n / TD > MAXU) ? MAXU : n / TD;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // every cycle: valid exactly on due cycles, outputs equal the last expected result
  task automatic run(int n);
    repeat (n) begin
      bit exp_v;
      @(negedge clk);
      exp_v = q.size() > 0 && q[0].due == cyc;
      if (exp_v) begin
        exp_h = q[0].h;
        exp_l = q[0].l;
        exp_o = q[0].o;
        void'(q.pop_front());
      end
      chk("valid", valid, exp_v);
      chk("high_units", high_units, exp_h);
      chk("low_units", low_units, exp_l);
      chk("ovf", ovf, exp_o);
    end
  endtask

  // a result exists for each rise that closes a full high+low pair seen since arming
  task automatic model_start(bit lvl, int n);
    if (lvl) begin
      if (armed && have_lo)
        q.push_back('{units(hi_len), units(lo_len),
                      int'(hi_len / TD >= MAXU || lo_len / TD >= MAXU), cyc + LAT});
      armed = 1;
      hi_len = n;
      have_lo = 0;
    end else if (armed) begin
      lo_len = n;
      have_lo = 1;
    end
  endtask

  task automatic ph(bit lvl, int n);
    model_start(lvl, n);
    wave_in = lvl;
    run(n);
  endtask

  task automatic per(int h, int l);
    ph(1, h);
    ph(0, l);
  endtask

  initial begin
    reset = 1;
    en = 1;
    wave_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_high", high_units, 0);
    chk("rst_low", low_units, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_locked", locked, 0);
    reset = 0;
    run(10);
    repeat (4) per(30, 50);
    chk("locked_run", locked, 1);
    repeat (2) per(29, 31);
    per(20, 3000);
    repeat (2) per(30, 50);
    ph(1, 30);
`ifdef WAVE_METER_GLITCH_FILTER_EN
    model_start(0, 50);
    wave_in = 0;
    run(20);
    wave_in = 1;
    run(2);
    wave_in = 0;
    run(28);
`else
    ph(0, 20);
    ph(1, 2);
    ph(0, 28);
`endif
    repeat (2) per(30, 50);
    ph(1, 30);
    ph(0, 20);
    en = 0;
    armed = 0;
    run(5);
    chk("locked_en_off", locked, 0);
    en = 1;
    run(25);
    repeat (2) per(30, 50);
    repeat (20) per($urandom_range(3, 700), $urandom_range(3, 700));
    per(30, 50);
    ph(1, 15);
    #1 reset = 1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_high", high_units, 0);
    chk("arst_low", low_units, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_locked", locked, 0);
    q.delete();
    armed = 0;
    have_lo = 0;
    exp_h = 0;
    exp_l = 0;
    exp_o = 0;
    wave_in = 0;
    run(3);
    reset = 0;
    run(10);
    repeat (2) per(30, 50);
    ph(1, 20);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
